// File: rtl/mem_access_unit.sv
// Byte-port load/store engine: splits big-endian halfword accesses into two byte
// accesses, range-checks every request and answers with a one-cycle response pulse.
module mem_access_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_BYTES);

  logic [1:0]        state_q, state_d;
  logic              write_q, byte_q, signed_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [7:0]        hi_q, lo_q;

  logic              accept;
  logic [ADDR_W:0]   nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              range_err;
  logic              in_access;

  assign accept = req_valid && req_ready;

  // One extra bit so that 16'hFFFF + 2 overflows upward instead of wrapping to 0.
  assign nbytes    = req_byte ? (ADDR_W+1)'(1) : (ADDR_W+1)'(2);
  assign end_addr  = {1'b0, req_addr} + nbytes;
  assign range_err = {1'b0, end_addr} > MEM_LIMIT;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = range_err ? ST_RESP : ST_HI;
      ST_HI:   state_d = byte_q ? ST_RESP : ST_LO;
      ST_LO:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      byte_q   <= req_byte;
      signed_q <= req_signed;
      err_q    <= range_err;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // NOTE: the load holding registers are reset too, so a response can never expose stale data from before reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!write_q) begin
      if (state_q == ST_HI) begin
        if (byte_q) lo_q <= mem_rdata;
        else        hi_q <= mem_rdata;
      end else if (state_q == ST_LO) begin
        lo_q <= mem_rdata;
      end
    end
  end

  // Memory-side outputs are decoded from the state register alone, so reset drops them at once.
  assign in_access = (state_q == ST_HI) || (state_q == ST_LO);
  assign req_ready = (state_q == ST_IDLE);
  assign mem_re    = in_access && !write_q;
  assign mem_we    = in_access && write_q;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (state_q == ST_HI) begin
      mem_addr = addr_q;
      if (write_q) mem_wdata = byte_q ? wdata_q[7:0] : wdata_q[15:8];
    end else if (state_q == ST_LO) begin
      mem_addr = addr_q + ADDR_W'(1);
      if (write_q) mem_wdata = wdata_q[7:0];
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_error = resp_valid && err_q;

  always_comb begin
    resp_rdata = 16'h0000;
    if (resp_valid && !err_q && !write_q) begin
      resp_rdata = byte_q ? {{8{signed_q & lo_q[7]}}, lo_q} : {hi_q, lo_q};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-wide memory, directed corner cases, back-to-back
// traffic and random requests compared against an array-based reference model.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 64;
  localparam int ADDR_W    = 16;
  localparam int AW        = $clog2(MEM_BYTES);

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic              req_byte = 1'b0;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [15:0]       req_wdata = '0;
  logic              resp_valid;
  logic [15:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Byte memory seen by the DUT, plus a preload port used while in reset.
  logic [7:0]    mem [MEM_BYTES];
  logic [7:0]    ref_mem [MEM_BYTES];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we && int'(mem_addr) < MEM_BYTES) mem[mem_addr[AW-1:0]] <= mem_wdata;
  end

  always_comb begin
    mem_rdata = 8'h00;
    if (int'(mem_addr) < MEM_BYTES) mem_rdata = mem[mem_addr[AW-1:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: outcome of one request from the range rule and big-endian byte layout.
  task automatic model(input logic w, input logic b, input logic s, input logic [15:0] a,
                       input logic [15:0] wd, output logic [15:0] rd, output logic er,
                       output int lat);
    int nb;
    int ai;
    nb = b ? 1 : 2;
    ai = int'(a);
    er = (ai + nb) > MEM_BYTES;
    rd = 16'h0000;
    if (er) begin
      lat = 1;
    end else begin
      lat = b ? 2 : 3;
      if (!w) begin
        if (b) rd = {((s && ref_mem[ai][7]) ? 8'hFF : 8'h00), ref_mem[ai]};
        else   rd = {ref_mem[ai], ref_mem[ai+1]};
      end else if (b) begin
        ref_mem[ai] = wd[7:0];
      end else begin
        ref_mem[ai]   = wd[15:8];
        ref_mem[ai+1] = wd[7:0];
      end
    end
  endtask

  // Single request: checks latency, response and every memory strobe cycle.
  task automatic run_req(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] wd);
    logic [15:0] exp_rd;
    logic        exp_er;
    int          exp_lat;
    int          k;
    int          re_n;
    int          we_n;
    bit          got;
    model(w, b, s, a, wd, exp_rd, exp_er, exp_lat);
    @(negedge clock);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_wdata = 16'(~wd);
    k = 0; re_n = 0; we_n = 0; got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clock);
      if (mem_re && mem_we) check("strobes_exclusive", 32'd1, 32'd0);
      if (mem_re || mem_we) begin
        check("strobe_addr", 32'(mem_addr), 32'(16'(a + 16'(k))));
        if (mem_we)
          check("strobe_wdata", 32'(mem_wdata),
                32'((b || k == 1) ? wd[7:0] : wd[15:8]));
        if (mem_re) re_n++;
        if (mem_we) we_n++;
        k++;
      end
      if (resp_valid) begin
        got = 1'b1;
        check("latency", 32'(c), 32'(exp_lat));
        check("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
        check("resp_error", 32'(resp_error), 32'(exp_er));
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("re_cycles", 32'(re_n), 32'((w || exp_er) ? 0 : (b ? 1 : 2)));
    check("we_cycles", 32'(we_n), 32'((!w || exp_er) ? 0 : (b ? 1 : 2)));
  endtask

  // Back-to-back stream: req_valid held high, four requests.
  logic        bb_w [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        bb_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        bb_s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] bb_a [4] = '{16'd20, 16'd21, 16'd20, 16'd63};
  logic [15:0] bb_d [4] = '{16'h12F4, 16'h0000, 16'h0000, 16'h0000};

  task automatic run_b2b();
    logic [15:0] exp_rd_q [$];
    logic        exp_er_q [$];
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          idx;
    int          busy;
    int          n_resp;
    bit          rdy;
    idx = 0; busy = 0; n_resp = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = bb_w[0]; req_byte = bb_b[0]; req_signed = bb_s[0];
    req_addr = bb_a[0]; req_wdata = bb_d[0];
    for (int cyc = 0; cyc < 40 && (idx < 4 || busy > 0); cyc++) begin
      check("b2b_ready", 32'(req_ready), 32'(busy == 0));
      check("b2b_resp_timing", 32'(resp_valid), 32'(busy == 1));
      if (resp_valid) begin
        n_resp++;
        if (exp_rd_q.size() == 0) begin
          check("b2b_extra_resp", 32'd1, 32'd0);
        end else begin
          check("b2b_rdata", 32'(resp_rdata), 32'(exp_rd_q.pop_front()));
          check("b2b_error", 32'(resp_error), 32'(exp_er_q.pop_front()));
        end
      end
      rdy = req_ready && (idx < 4);
      @(posedge clock);
      if (rdy) begin
        model(bb_w[idx], bb_b[idx], bb_s[idx], bb_a[idx], bb_d[idx], rd, er, lat);
        exp_rd_q.push_back(rd);
        exp_er_q.push_back(er);
        busy = lat;
        idx++;
      end else if (busy > 0) begin
        busy--;
      end
      #1;
      if (idx < 4) begin
        req_write = bb_w[idx]; req_byte = bb_b[idx]; req_signed = bb_s[idx];
        req_addr = bb_a[idx]; req_wdata = bb_d[idx];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    check("b2b_accepted", 32'(idx), 32'd4);
    check("b2b_responses", 32'(n_resp), 32'd4);
  endtask

  initial begin
    logic        w, b, s;
    logic [15:0] a, wd;
    int          r;

    // Preload memory during reset, mirrored into the reference.
    for (int i = 0; i < MEM_BYTES; i++) begin
      @(negedge clock);
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = 8'($urandom);
      ref_mem[i] = pre_data;
    end
    @(negedge clock);
    pre_we = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    reset_n = 1'b1;

    run_req(1'b1, 1'b0, 1'b0, 16'd4, 16'hA55A);
    check("mem4", 32'(mem[4]), 32'h A5);
    check("mem5", 32'(mem[5]), 32'h5A);
    run_req(1'b0, 1'b0, 1'b0, 16'd4, 16'h0000);
    run_req(1'b1, 1'b1, 1'b0, 16'd5, 16'h339C);
    run_req(1'b0, 1'b1, 1'b1, 16'd5, 16'h0000);
    run_req(1'b0, 1'b1, 1'b0, 16'd5, 16'h0000);
    run_req(1'b0, 1'b0, 1'b0, 16'(MEM_BYTES - 1), 16'h0000);
    run_req(1'b0, 1'b1, 1'b1, 16'(MEM_BYTES - 1), 16'h0000);
    run_req(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hDEAD);
    run_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h00EE);
    check("mem0_untouched", 32'(mem[0]), 32'(ref_mem[0]));

    // Reset in the LO cycle of a halfword store: strobe must drop with no clock edge.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'd10;
    req_wdata = 16'hBEEF;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 check("midlo_we_before", 32'(mem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midlo_we_drop", 32'(mem_we), 32'd0);
    check("midlo_re_drop", 32'(mem_re), 32'd0);
    check("midlo_ready", 32'(req_ready), 32'd1);
    check("midlo_no_resp", 32'(resp_valid), 32'd0);
    ref_mem[10] = 8'hBE;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("midlo_no_late_resp", 32'(resp_valid), 32'd0);
    end

    run_b2b();

    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom); b = 1'($urandom); s = 1'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 16'hFFFF;
      else if (r == 1) a = 16'(MEM_BYTES - 1);
      else             a = 16'($urandom_range(0, MEM_BYTES + 2));
      wd = 16'($urandom);
      run_req(w, b, s, a, wd);
    end

    @(negedge clock);
    for (int i = 0; i < MEM_BYTES; i++) check("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
